// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file dump reader: widths, opcode
// constants used across the core, and the dump FSM state encoding.
package reg_dump_pkg;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int DEPTH = 2 ** D;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} dump_state_t;

  function automatic logic [D-1:0] next_addr(input logic [D-1:0] a);
    return a + D'(1);
  endfunction

endpackage

// File: rtl/reg_dump_if.sv
// Bundle of the dump reader's control, register-file read port and output
// stream; slave is the reader side, master is the driver/consumer side.
interface reg_dump_if;
  import reg_dump_pkg::*;

  logic         start;
  logic [D-1:0] first_addr;
  logic [D-1:0] last_addr;
  logic [D-1:0] raddr;
  logic [W-1:0] rdata;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [D-1:0] out_addr;
  logic         out_last;
  logic         busy;
  logic         done;

  modport slave (
    input  start, first_addr, last_addr, rdata, out_ready,
    output raddr, out_valid, out_data, out_addr, out_last, busy, done
  );

  modport master (
    output start, first_addr, last_addr, rdata, out_ready,
    input  raddr, out_valid, out_data, out_addr, out_last, busy, done
  );

endinterface

// File: rtl/reg_dump.sv
// Walks a (possibly wrapping) register range through a dedicated read port
// and streams each snapshotted register as an (address, data) word.
module reg_dump
  import reg_dump_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_reset_n,
  reg_dump_if.slave bus
);

  dump_state_t  r_state,    w_state_nxt;
  logic [D-1:0] r_ptr,      w_ptr_nxt;
  logic [D-1:0] r_end_ptr,  w_end_ptr_nxt;
  logic [W-1:0] r_out_data, w_out_data_nxt;
  logic [D-1:0] r_out_addr, w_out_addr_nxt;
  logic         r_out_last, w_out_last_nxt;
  logic         r_out_valid, w_out_valid_nxt;

  // NOTE: every comb output is given its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_end_ptr_nxt   = r_end_ptr;
    w_out_data_nxt  = r_out_data;
    w_out_addr_nxt  = r_out_addr;
    w_out_last_nxt  = r_out_last;
    w_out_valid_nxt = r_out_valid;

    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_ptr_nxt     = bus.first_addr;
          w_end_ptr_nxt = bus.last_addr;
          w_state_nxt   = LOAD;
        end
      end
      LOAD: begin
        w_out_data_nxt  = bus.rdata;
        w_out_addr_nxt  = r_ptr;
        w_out_last_nxt  = (r_ptr == r_end_ptr);
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = SEND;
      end
      SEND: begin
        if (r_out_valid && bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_out_last) begin
            w_state_nxt = FIN;
          end else begin
            // Pointer wraps modulo the register file depth.
            w_ptr_nxt   = next_addr(r_ptr);
            w_state_nxt = LOAD;
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_end_ptr   <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_end_ptr   <= w_end_ptr_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_addr  <= w_out_addr_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // busy and done decode the state register only, so they drop as soon as reset asserts.
  assign bus.raddr     = r_ptr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_last  = r_out_last;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == FIN);

endmodule

// File: doc/reg_dump.md
# reg_dump

Sequential reader for the 16-entry register file: on a start pulse it walks a programmable address range through a dedicated combinational read port, snapshots each register, and emits it as an (address, data) word on a valid/ready stream. It sits beside the register file and feeds the testbench trace logger and the end-of-program result checker, giving them visibility into architectural state without touching the datapath read ports.

## Interface
- W, 8, data path width (matches register file)
- D, 4, address width; register file depth is 2**D
- CLK  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump; ignored while busy=1
- first_addr  in  D  first register of range, sampled on accepted start
- last_addr  in  D  last register of range, sampled on accepted start
- raddr  out  D  address to register file dump read port
- rdata  in  W  combinational read data for raddr
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer ready
- out_data  out  W  snapshotted register value
- out_addr  out  D  address of out_data
- out_last  out  1  word is final word of range
- busy  out  1  dump in progress (any state except IDLE)
- done  out  1  one-cycle pulse after final word accepted

## Operation
- Reset is asynchronous and active-low. While reset_n=0: state=IDLE; ptr, end_ptr, raddr, out_data, out_addr = 0; out_valid, out_last, busy, done = 0. Reset mid-dump aborts; no partial state survives.
- States: IDLE, LOAD, SEND, FIN.
- IDLE: start=1 -> ptr<=first_addr, end_ptr<=last_addr, go LOAD.
- LOAD: raddr=ptr; out_data<=rdata, out_addr<=ptr, out_last<=(ptr==end_ptr), out_valid<=1; go SEND.
- SEND: hold all out_* stable while out_ready=0. On out_valid&&out_ready: out_valid<=0; if out_last go FIN, else ptr<=ptr+1 (mod 2**D) and go LOAD.
- FIN: done=1 for this cycle only; go IDLE.
- Range wraps: last_addr < first_addr dumps first..2**D-1, then 0..last_addr. first_addr==last_addr emits exactly one word. Full sweep uses first=0, last=2**D-1 (16 words).
- Snapshot: out_data is registered at LOAD; register file writes during SEND do not alter the held word, but are visible to later LOADs.
- start while busy=1 (including FIN) is ignored; no queuing.
- raddr is driven from ptr in all states, so it holds a stable value; the register file read port has no enable.

## Timing
- Accepted start at edge k -> LOAD during cycle k..k+1; out_valid=1 after edge k+1.
- With out_ready held 1: one word every 2 cycles; N-word range completes in 2N cycles after start; done is high in the cycle after the final handshake edge.
- out_valid never falls without a handshake; out_data/out_addr/out_last do not change while out_valid=1.
- No combinational path from out_ready to any output; start to busy is registered (busy rises one edge after start).

## Structure
- Add typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} dump_state_t to the shared definitions package, alongside the opcode constants; the trace logger also decodes it for debug.
- Single module, no sub-module; ptr/end_ptr counter and FSM are inline. Register file gains one extra combinational read port (raddr/rdata) for this block.

## Test plan
- Full sweep: preload reg i = 8'h10+i, first=0, last=15, out_ready=1 -> 16 words, addrs 0..15, data 8'h10..8'h1F, out_last only on addr 15, done pulse at 32 cycles after start.
- Wrap range: first=14, last=1 -> addrs 14,15,0,1 in order, out_last on addr 1.
- Single word and back-pressure: first=last=5, reg5=8'hA5, out_ready low for 7 cycles -> out_valid/out_data=8'hA5/out_addr=5 held stable for all 7, accepted on first ready cycle, done one cycle later.
- Snapshot: during SEND of addr 3 (value 8'h33), write reg3=8'hFF and reg4=8'h44 -> emitted words are 8'h33 for addr 3 and 8'h44 for addr 4.
- Start while busy: second start mid-dump with different range -> ignored, original range completes unchanged, exactly one done pulse.
- Async reset mid-dump: assert reset_n=0 between clock edges during SEND -> out_valid, busy, done drop to 0 immediately; after release, new start dumps correctly from first_addr.
